// File: rtl/index_sram_pkg.sv
// Shared types and default geometry for the pooling-index SRAM controller.
package index_sram_pkg;

  localparam int IDX_W_DEF = 2;
  localparam int PACK_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WFLUSH,
    RFETCH,
    RWAIT,
    ROUT
  } state_e;

endpackage

// File: rtl/index_sram_ctrl_sram.sv
// Simple dual-port word SRAM: one synchronous write port, one registered read port.
module INDEX_SRAM #(
  parameter int WR_DATA_WIDTH = 16,
  parameter int WR_DATA_DEPTH = 1024,
  parameter int RD_DATA_WIDTH = 16,
  parameter int RD_DATA_DEPTH = 1024,
  localparam int WA_W = (WR_DATA_DEPTH > 1) ? $clog2(WR_DATA_DEPTH) : 1,
  localparam int RA_W = (RD_DATA_DEPTH > 1) ? $clog2(RD_DATA_DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [WA_W-1:0]          waddr_i,
  input  logic [WR_DATA_WIDTH-1:0] din_i,
  input  logic [RA_W-1:0]          raddr_i,
  output logic [RD_DATA_WIDTH-1:0] dout_o
);

  logic [WR_DATA_WIDTH-1:0] mem_q [WR_DATA_DEPTH];

  // NOTE: the array has no reset so it maps onto a real SRAM macro; contents persist across rst.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[waddr_i] <= din_i;
      dout_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/index_sram_ctrl.sv
// Packs a frame of pooling indices into SRAM words, then replays them in order.
module index_sram_ctrl
  import index_sram_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int PACK  = PACK_DEF,
  parameter int DEPTH = 1024,
  localparam int WORD_W = IDX_W * PACK,
  localparam int LEN_W  = $clog2(DEPTH * PACK) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             wr_valid,
  input  logic [IDX_W-1:0] wr_idx,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [IDX_W-1:0] rd_idx,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LEN_W-1:0]  MAX_LEN   = LEN_W'(DEPTH * PACK);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PACK - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [WORD_W-1:0]   unpack_q, unpack_d;
  logic                wpend_q, wpend_d;
  logic                done_q, done_d;

  logic [WORD_W-1:0]   word;
  logic                last;
  logic                sram_we;
  logic [ADDR_W-1:0]   sram_waddr;
  logic [WORD_W-1:0]   sram_din;
  logic [WORD_W-1:0]   sram_dout;

  assign sram_we    = wpend_q;
  assign sram_waddr = waddr_q;
  assign sram_din   = hold_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    pack_d   = pack_q;
    hold_d   = hold_q;
    unpack_d = unpack_q;
    wpend_d  = 1'b0;
    done_d   = 1'b0;
    wr_ready = 1'b0;
    rd_valid = 1'b0;
    rd_idx   = '0;
    word     = pack_q;
    last     = 1'b0;

    // A word staged last cycle retires now, so the write pointer moves on.
    if (wpend_q) waddr_d = (waddr_q == LAST_ADDR) ? '0 : waddr_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
            cnt_d   = '0;
            slot_d  = '0;
            waddr_d = '0;
            pack_d  = '0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          word[slot_q*IDX_W +: IDX_W] = wr_idx;
          last  = (cnt_q == len_q - LEN_W'(1));
          cnt_d = cnt_q + LEN_W'(1);
          if (last || slot_q == LAST_SLOT) begin
            hold_d  = word;
            wpend_d = 1'b1;
            pack_d  = '0;
            slot_d  = '0;
          end else begin
            pack_d = word;
            slot_d = slot_q + SLOT_W'(1);
          end
          if (last) state_d = WFLUSH;
        end
      end
      WFLUSH: begin
        raddr_d = '0;
        cnt_d   = '0;
        slot_d  = '0;
        state_d = RFETCH;
      end
      RFETCH: begin
        raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + ADDR_W'(1);
        state_d = RWAIT;
      end
      RWAIT: begin
        unpack_d = sram_dout;
        state_d  = ROUT;
      end
      ROUT: begin
        rd_valid = 1'b1;
        rd_idx   = unpack_q[slot_q*IDX_W +: IDX_W];
        if (rd_ready) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (slot_q == LAST_SLOT) begin
            slot_d  = '0;
            state_d = RFETCH;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      slot_q   <= '0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      pack_q   <= '0;
      hold_q   <= '0;
      unpack_q <= '0;
      wpend_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      pack_q   <= pack_d;
      hold_q   <= hold_d;
      unpack_q <= unpack_d;
      wpend_q  <= wpend_d;
      done_q   <= done_d;
    end
  end

  INDEX_SRAM #(
    .WR_DATA_WIDTH(WORD_W),
    .WR_DATA_DEPTH(DEPTH),
    .RD_DATA_WIDTH(WORD_W),
    .RD_DATA_DEPTH(DEPTH)
  ) u_sram (
    .clk     (clk),
    .en_i    (1'b1),
    .we_i    (sram_we),
    .waddr_i (sram_waddr),
    .din_i   (sram_din),
    .raddr_i (raddr_q),
    .dout_o  (sram_dout)
  );

endmodule

// File: tb/tb_index_sram_ctrl.sv
// Directed bench for index_sram_ctrl: packing, replay order, flow control, reset and clamping.
module tb_index_sram_ctrl;

  localparam int IDX_W   = 2;
  localparam int PACK    = 8;
  localparam int DEPTH   = 1024;
  localparam int WORD_W  = IDX_W * PACK;
  localparam int LEN_W   = $clog2(DEPTH * PACK) + 1;
  localparam int MAX_LEN = DEPTH * PACK;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             wr_valid;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_ready;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_ready;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  logic [IDX_W-1:0]  exp_idx[$];
  logic [WORD_W-1:0] wlog_data[$];
  int                wlog_addr[$];

  always #5 clk = ~clk;

  index_sram_ctrl #(.IDX_W(IDX_W), .PACK(PACK), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_len  (cfg_len),
    .wr_valid (wr_valid),
    .wr_idx   (wr_idx),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_idx   (rd_idx),
    .rd_ready (rd_ready),
    .busy     (busy),
    .done     (done)
  );

  // Log every SRAM write the controller issues.
  always @(posedge clk) begin
    if (dut.sram_we) begin
      wlog_data.push_back(dut.sram_din);
      wlog_addr.push_back(int'(dut.sram_waddr));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int n, input int kind);
    exp_idx.delete();
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       exp_idx.push_back(IDX_W'(i % 4));
        1:       exp_idx.push_back(IDX_W'((i + i / PACK) % 4));
        default: exp_idx.push_back(IDX_W'((i * 3 + 1) % 4));
      endcase
    end
  endtask

  task automatic kick(input int len);
    @(negedge clk);
    start = 1'b1;
    cfg_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0;
    cfg_len = '0;
  endtask

  task automatic write_frame(input string tag, input int n, input int start_at);
    int i = 0;
    int cyc = 0;
    int bad_ready = 0;
    int bad_done = 0;
    while (i < n && cyc < n + 20) begin
      wr_valid = 1'b1;
      wr_idx   = exp_idx[i];
      start    = (i == start_at);
      cfg_len  = '0;
      if (done) bad_done++;
      if (wr_ready) i++;
      else bad_ready++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_accepted"}, i, n);
    check({tag, "_wr_ready_held"}, bad_ready, 0);
    check({tag, "_no_done_in_write"}, bad_done, 0);
    wr_idx = 2'd3;
    check({tag, "_wflush_ready"}, wr_ready, 1'b0);
    check({tag, "_wflush_busy"}, busy, 1'b1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic read_frame(input string tag, input int n, input bit toggle);
    int j = 0;
    int cyc = 0;
    int gap = 0;
    int bad_data = 0;
    int bad_gap = 0;
    int bad_hold = 0;
    int bad_done = 0;
    bit held_v = 1'b0;
    logic [IDX_W-1:0] held_idx = '0;
    while (j < n && cyc < 4 * n + 40) begin
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (held_v && (!rd_valid || rd_idx !== held_idx)) bad_hold++;
      if (done) bad_done++;
      held_v = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          if (rd_idx !== exp_idx[j]) bad_data++;
          if (gap != ((j % PACK == 0) ? 2 : 0)) bad_gap++;
          gap = 0;
          j++;
        end else begin
          held_v = 1'b1;
          held_idx = rd_idx;
        end
      end else begin
        gap++;
      end
      cyc++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    check({tag, "_handshakes"}, j, n);
    check({tag, "_order"}, bad_data, 0);
    check({tag, "_latency"}, bad_gap, 0);
    check({tag, "_hold_stable"}, bad_hold, 0);
    check({tag, "_early_done"}, bad_done, 0);
    check({tag, "_done_pulse"}, done, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_rd_valid"}, rd_valid, 1'b0);
    @(negedge clk);
    check({tag, "_done_single"}, done, 1'b0);
  endtask

  task automatic check_words(input string tag, input int n);
    int nw = (n + PACK - 1) / PACK;
    int bad = 0;
    logic [WORD_W-1:0] w;
    check({tag, "_nwrites"}, wlog_data.size(), nw);
    for (int k = 0; k < nw && k < wlog_data.size(); k++) begin
      w = '0;
      for (int s = 0; s < PACK; s++)
        if (k * PACK + s < n) w[s*IDX_W +: IDX_W] = exp_idx[k*PACK+s];
      if (wlog_data[k] !== w || wlog_addr[k] != k % DEPTH) bad++;
    end
    check({tag, "_words"}, bad, 0);
  endtask

  task automatic clear_log();
    wlog_data.delete();
    wlog_addr.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = '0;
    wr_valid = 1'b0; wr_idx = '0; rd_ready = 1'b0;
    #2;
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_idx", rd_idx, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-length frame: immediate done, never busy.
    kick(0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    @(negedge clk);
    check("zero_done_single", done, 1'b0);
    check("zero_busy_after", busy, 1'b0);

    // 16 indices 0,1,2,3 repeating: two full words.
    clear_log();
    fill(16, 0);
    kick(16);
    write_frame("f16", 16, -1);
    read_frame("f16", 16, 1'b0);
    check_words("f16", 16);
    check("f16_word0", wlog_data.size() > 0 ? wlog_data[0] : 'x, 16'hE4E4);
    check("f16_word1", wlog_data.size() > 1 ? wlog_data[1] : 'x, 16'hE4E4);

    // 11 indices with a stray start mid-write: partial second word.
    clear_log();
    fill(11, 0);
    kick(11);
    write_frame("f11", 11, 4);
    read_frame("f11", 11, 1'b0);
    check_words("f11", 11);
    check("f11_word1", wlog_data.size() > 1 ? wlog_data[1] : 'x, 16'h0024);

    // Toggling rd_ready with wr_valid left high during replay.
    clear_log();
    fill(20, 1);
    kick(20);
    write_frame("f20t", 20, -1);
    wr_valid = 1'b1;
    read_frame("f20t", 20, 1'b1);
    wr_valid = 1'b0;
    check_words("f20t", 20);

    // Reset in the middle of a 16-index frame.
    clear_log();
    fill(16, 0);
    kick(16);
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_idx = exp_idx[i];
      @(negedge clk);
    end
    rst = 1'b1;
    wr_valid = 1'b0;
    #1;
    check("midrst_wr_ready", wr_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rd_valid", rd_valid, 1'b0);
    check("midrst_rd_idx", rd_idx, 2'd0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    clear_log();
    fill(8, 2);
    kick(8);
    write_frame("f8", 8, -1);
    read_frame("f8", 8, 1'b0);
    check_words("f8", 8);
    check("f8_word0", wlog_data.size() > 0 ? wlog_data[0] : 'x, 16'hB1B1);

    // Oversized length is clamped to the full SRAM capacity.
    clear_log();
    fill(MAX_LEN, 1);
    kick(MAX_LEN + 5);
    write_frame("fmax", MAX_LEN, -1);
    read_frame("fmax", MAX_LEN, 1'b0);
    check_words("fmax", MAX_LEN);
    check("fmax_last_addr", wlog_addr.size() > 0 ? wlog_addr[wlog_addr.size()-1] : -1, DEPTH - 1);
    check("fmax_waddr_wrap", dut.waddr_q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/index_sram_ctrl.md
INDEX_SRAM_CTRL -- requirements
Module: index_sram_ctrl

Interface
REQ-001 Parameter IDX_W, default 2, sets the width of one pooling index in bits.
REQ-002 Parameter PACK, default 8, sets the number of indices packed per SRAM word; WORD_W = IDX_W*PACK.
REQ-003 Parameter DEPTH, default 1024, sets the number of SRAM words; LEN_W = $clog2(DEPTH*PACK)+1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse that begins a frame; honoured only in IDLE.
REQ-007 cfg_len  input  LEN_W  number of indices in the frame; sampled when start is accepted.
REQ-008 wr_valid  input  1  producer (pooling stage) offers wr_idx.
REQ-009 wr_idx  input  IDX_W  index value offered by the producer.
REQ-010 wr_ready  output  1  controller accepts wr_idx in this cycle.
REQ-011 rd_valid  output  1  rd_idx is valid for the consumer (unpooling stage).
REQ-012 rd_idx  output  IDX_W  index value replayed to the consumer.
REQ-013 rd_ready  input  1  consumer takes rd_idx in this cycle.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  single-cycle pulse when the last index of a frame has been consumed.

Function
REQ-016 States SHALL be IDLE, WRITE, WFLUSH, RFETCH, RWAIT, ROUT.
REQ-017 IDLE: on start with cfg_len=0, pulse done next cycle and remain in IDLE; on start with cfg_len>0, load the length and go to WRITE.
REQ-018 cfg_len > DEPTH*PACK SHALL be clamped to DEPTH*PACK.
REQ-019 WRITE: wr_ready=1; a transfer occurs when wr_valid&&wr_ready, with the index placed in slot k of the pack register (slot 0 = bits [IDX_W-1:0]).
REQ-020 On the accepted transfer that fills slot PACK-1, or that carries the frame's last index, the word (unfilled slots zero) is copied to a write-hold register and written to the SRAM at the write address in the next cycle; the write address then increments.
REQ-021 On the last index, go to WFLUSH (wr_ready=0) for exactly one cycle while the final write retires, then go to RFETCH with the read address and remaining count reset.
REQ-022 RFETCH issues one SRAM read; RWAIT latches sram dout into the unpack register one cycle later; then go to ROUT.
REQ-023 ROUT: rd_valid=1 and rd_idx=slot j of the unpack register; rd_idx and rd_valid SHALL hold stable while rd_ready=0.
REQ-024 On rd_valid&&rd_ready: if the frame is exhausted, pulse done and go to IDLE; else if j=PACK-1, go to RFETCH; else j increments.
REQ-025 Read latency from entering RFETCH to rd_valid SHALL be exactly 2 cycles; rd_valid is low in RFETCH and RWAIT.
REQ-026 Replay order SHALL equal write order, including across word boundaries and partial last words.
REQ-027 start outside IDLE, wr_valid outside WRITE, and rd_ready outside ROUT SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE asynchronously, with wr_ready=0, rd_valid=0, rd_idx=0, busy=0, done=0, and all counters, addresses and pack/unpack registers at 0.
REQ-029 Reset mid-frame SHALL abandon the frame; SRAM contents are not cleared, and the next frame overwrites them from address 0.

Structure
REQ-030 Shared package index_sram_pkg SHALL hold the state enum type and the default IDX_W/PACK constants.
REQ-031 The block SHALL instantiate exactly one INDEX_SRAM sub-module, with WR/RD_DATA_WIDTH=WORD_W and WR/RD_DATA_DEPTH=DEPTH, with en tied high.

Verification
REQ-032 cfg_len=16, indices 0,1,2,3 repeating, wr_valid held high -> two SRAM writes of 16'hE4E4, then 16 reads in identical order and done one cycle after the 16th handshake.
REQ-033 cfg_len=11 -> second word written with slots 3..7 zero; exactly 11 rd handshakes; done pulses once.
REQ-034 rd_ready toggled 1/0 every cycle -> rd_idx stable whenever rd_ready=0; no index is lost or duplicated.
REQ-035 start with cfg_len=0 -> done pulses one cycle later and busy stays 0; start pulsed during WRITE -> no effect.
REQ-036 rst asserted after the 5th write of a 16-index frame -> outputs reach reset values immediately; a following 8-index frame replays correctly.
REQ-037 cfg_len=DEPTH*PACK+5 -> exactly DEPTH*PACK indices accepted and replayed; the write address wraps to 0 without writing beyond DEPTH-1.
